// File: rtl/therm_level_stepper.sv
// Debounces a 7-bit thermometer input and emits active-low up/down strobes that walk a
// downstream bar-graph counter to the accepted level; accept after STABLE_CYCLES+3 edges.
module therm_level_stepper #(
    parameter int STABLE_CYCLES = 4,
    parameter int PULSE_W       = 1,
    parameter int GAP_W         = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] therm,
    input  logic       clr_n,
    output logic [2:0] level,
    output logic       err,
    output logic       up_n,
    output logic       down_n,
    output logic [2:0] track,
    output logic       busy
);

    localparam int CW   = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
    localparam int TMAX = (PULSE_W > GAP_W) ? PULSE_W : GAP_W;
    localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_CYCLES - 1);
    localparam logic [TW-1:0] P_LAST   = TW'(PULSE_W - 1);
    localparam logic [TW-1:0] G_LAST   = TW'(GAP_W - 1);

    typedef enum logic [1:0] {IDLE, PULSE, GAP} state_t;

    logic [6:0]    s1, s2, cand;
    logic [CW-1:0] cnt;
    state_t        state;
    logic [TW-1:0] tcnt;
    logic          legal;
    logic [2:0]    cand_ones;
    logic          want_up, want_dn, step_slot;

    always_comb begin
        cand_ones = 3'd0;
        for (int i = 0; i < 7; i++) begin
            cand_ones = cand_ones + {2'b00, cand[i]};
        end
    end

    // A legal thermometer code is all-ones below its top set bit, so +1 clears every set bit.
    assign legal = ((({1'b0, cand} + 8'd1) & {1'b0, cand}) == 8'd0);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1    <= '0;
            s2    <= '0;
            cand  <= '0;
            cnt   <= '0;
            level <= '0;
            err   <= 1'b0;
        end else begin
            s1 <= therm;
            s2 <= s1;
            if (s2 != cand) begin
                cand <= s2;
                cnt  <= '0;
            end else if (cnt == CNT_LAST) begin
                if (legal) begin
                    level <= cand_ones;
                    err   <= 1'b0;
                end else begin
                    err   <= 1'b1;
                end
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    assign want_up   = !err && (level > track);
    assign want_dn   = !err && (level < track);
    // Decision point: sitting idle, or the last GAP cycle so back-to-back steps need no idle cycle.
    assign step_slot = (state == IDLE) || ((state == GAP) && (tcnt == G_LAST));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= IDLE;
            tcnt   <= '0;
            up_n   <= 1'b1;
            down_n <= 1'b1;
            track  <= '0;
            busy   <= 1'b0;
        end else if (!clr_n) begin
            state  <= IDLE;
            tcnt   <= '0;
            up_n   <= 1'b1;
            down_n <= 1'b1;
            track  <= '0;
            busy   <= 1'b0;
        end else if (step_slot) begin
            tcnt <= '0;
            if (want_up) begin
                state <= PULSE;
                up_n  <= 1'b0;
                track <= track + 3'd1;
                busy  <= 1'b1;
            end else if (want_dn) begin
                state  <= PULSE;
                down_n <= 1'b0;
                track  <= track - 3'd1;
                busy   <= 1'b1;
            end else begin
                state <= IDLE;
                busy  <= 1'b0;
            end
        end else if (state == PULSE) begin
            if (tcnt == P_LAST) begin
                state  <= GAP;
                tcnt   <= '0;
                up_n   <= 1'b1;
                down_n <= 1'b1;
            end else begin
                tcnt <= tcnt + 1'b1;
            end
        end else begin
            tcnt <= tcnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_therm_level_stepper.sv
// Randomized and directed bench for therm_level_stepper against a countdown-based reference model.
module tb_therm_level_stepper;

    localparam int SC = 4;
    localparam int PW = 1;
    localparam int GW = 2;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [6:0] therm;
    logic       clr_n;
    logic [2:0] level;
    logic       err;
    logic       up_n;
    logic       down_n;
    logic [2:0] track;
    logic       busy;

    int total = 0;
    int bad   = 0;
    int up_cnt, dn_cnt;

    therm_level_stepper #(.STABLE_CYCLES(SC), .PULSE_W(PW), .GAP_W(GW)) dut (
        .clk(clk), .rst_n(rst_n), .therm(therm), .clr_n(clr_n),
        .level(level), .err(err), .up_n(up_n), .down_n(down_n),
        .track(track), .busy(busy)
    );

    always #5 clk = ~clk;

    // Reference: samples pass a 2-deep delay, a code is taken once it has been seen SC+1 times
    // in a row (the reset candidate counts as one), and a step is a countdown of PW+GW cycles.
    logic [6:0] m_s1, m_s2, m_val;
    int         m_run, m_left, m_n;
    logic [2:0] m_level, m_track;
    logic       m_err, m_dir_up;

    initial m_dir_up = 1'b0;

    always @(posedge clk) begin
        if (!rst_n) begin
            m_s1 = '0; m_s2 = '0; m_val = '0; m_run = 1;
            m_level = '0; m_err = 1'b0; m_track = '0; m_left = 0;
        end else begin
            if (!clr_n) begin
                m_track = '0;
                m_left  = 0;
            end else if (m_left > 1) begin
                m_left--;
            end else if (!m_err && m_level != m_track) begin
                m_dir_up = (m_level > m_track);
                m_track  = m_dir_up ? m_track + 3'd1 : m_track - 3'd1;
                m_left   = PW + GW;
            end else begin
                m_left = 0;
            end
            if (m_s2 == m_val) begin
                if (m_run < SC + 1) m_run++;
            end else begin
                m_val = m_s2;
                m_run = 1;
            end
            if (m_run >= SC + 1) begin
                m_n = $countones(m_val);
                if (int'(m_val) == (1 << m_n) - 1) begin
                    m_level = 3'(m_n);
                    m_err   = 1'b0;
                end else begin
                    m_err = 1'b1;
                end
            end
            m_s2 = m_s1;
            m_s1 = therm;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(negedge clk);
            chk("level",  32'(level),  32'(m_level));
            chk("err",    32'(err),    32'(m_err));
            chk("up_n",   32'(up_n),   32'(!(m_left > GW && m_dir_up)));
            chk("down_n", 32'(down_n), 32'(!(m_left > GW && !m_dir_up)));
            chk("track",  32'(track),  32'(m_track));
            chk("busy",   32'(busy),   32'(m_left != 0));
            if (!up_n)   up_cnt++;
            if (!down_n) dn_cnt++;
        end
    endtask

    task automatic clr_counts();
        up_cnt = 0;
        dn_cnt = 0;
    endtask

    initial begin
        logic found;
        int   k;
        rst_n = 1'b0;
        clr_n = 1'b1;
        therm = 7'b0000111;
        clr_counts();

        // reset, then first level
        cyc(3);
        chk("rst_level", 32'(level), 0);
        chk("rst_up_n", 32'(up_n), 1);
        rst_n = 1'b1;
        cyc(6);
        chk("lvl_e6", 32'(level), 0);
        cyc(1);
        chk("lvl_e7", 32'(level), 3);
        cyc(12);
        chk("first_up", 32'(up_cnt), 3);
        chk("first_dn", 32'(dn_cnt), 0);
        chk("first_track", 32'(track), 3);
        chk("first_busy", 32'(busy), 0);

        // glitch rejection
        therm = 7'b0;
        cyc(40);
        clr_counts();
        therm = 7'b0000001;
        cyc(2);
        therm = 7'b0;
        cyc(15);
        chk("glitch_strobes", 32'(up_cnt + dn_cnt), 0);
        chk("glitch_level", 32'(level), 0);

        // illegal code
        therm = 7'b0000111;
        cyc(40);
        clr_counts();
        therm = 7'b0000101;
        cyc(20);
        chk("ill_err", 32'(err), 1);
        chk("ill_level", 32'(level), 3);
        chk("ill_strobes", 32'(up_cnt + dn_cnt), 0);
        therm = 7'b0001111;
        cyc(15);
        chk("leg_err", 32'(err), 0);
        chk("leg_level", 32'(level), 4);
        chk("leg_up", 32'(up_cnt), 1);
        chk("leg_track", 32'(track), 4);

        // descend from 7 to 2
        therm = 7'h7f;
        cyc(30);
        chk("top_track", 32'(track), 7);
        clr_counts();
        therm = 7'b0000011;
        cyc(30);
        chk("desc_dn", 32'(dn_cnt), 5);
        chk("desc_up", 32'(up_cnt), 0);
        chk("desc_track", 32'(track), 2);

        // target changes mid-sequence
        therm = 7'b0;
        cyc(40);
        therm = 7'h7f;
        found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            cyc(1);
            if (track == 3'd2 && busy && up_n && down_n) found = 1'b1;
        end
        chk("gap_found", 32'(found), 1);
        therm = 7'b0000001;
        cyc(50);
        chk("mid_track", 32'(track), 1);

        // clear mid-operation
        therm = 7'b0011111;
        cyc(40);
        chk("pre_clr_track", 32'(track), 5);
        clr_n = 1'b0;
        cyc(1);
        chk("clr_track", 32'(track), 0);
        clr_n = 1'b1;
        clr_counts();
        cyc(20);
        chk("clr_up", 32'(up_cnt), 5);
        chk("clr_track_end", 32'(track), 5);

        // reset during a pulse
        therm = 7'h7f;
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            cyc(1);
            if (!up_n) found = 1'b1;
        end
        chk("pulse_found", 32'(found), 1);
        rst_n = 1'b0;
        cyc(1);
        chk("rst_pulse_up", 32'(up_n), 1);
        chk("rst_pulse_track", 32'(track), 0);
        rst_n = 1'b1;
        cyc(2);

        // random traffic
        for (int seg = 0; seg < 200; seg++) begin
            if ($urandom_range(0, 1) == 0) begin
                k = $urandom_range(0, 7);
                therm = 7'((1 << k) - 1);
            end else begin
                therm = 7'($urandom);
            end
            clr_n = ($urandom_range(0, 15) != 0);
            rst_n = ($urandom_range(0, 49) != 0);
            cyc(1);
            clr_n = 1'b1;
            rst_n = 1'b1;
            cyc($urandom_range(0, 14));
        end
        cyc(40);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
